// File: rtl/fifo_batch_reader.sv
// rtl/fifo_batch_reader.sv - counted-batch read controller for a show-ahead FIFO
module fifo_batch_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_abort,
  input  logic              i_f_empty_n,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_read,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_checksum,
  output logic [CNT_W-1:0]  o_remaining
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_read;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_checksum;
  logic [CNT_W-1:0]    r_remaining;

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides normal sequencing in any busy state
  always_comb begin
    w_next = r_state;
    if (i_abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_next = (i_len != '0) ? S_FETCH : S_FINISH;
          end
        end
        S_FETCH: begin
          if (w_read) begin
            w_next = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (r_out_valid && i_out_ready) begin
            w_next = (r_remaining == '0) ? S_FINISH : S_FETCH;
          end
        end
        S_FINISH: begin
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // State-decoded outputs; pop strobe depends only on state, flag and abort
  always_comb begin
    w_read = (r_state == S_FETCH) && i_f_empty_n && !i_abort;
    o_busy = (r_state != S_IDLE);
    o_done = (r_state == S_FINISH);
  end

  // Datapath: captured word, running checksum and words-left counter
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_checksum  <= '0;
      r_remaining <= '0;
    end else if (i_abort && (r_state != S_IDLE)) begin
      // Partial checksum is kept; a word held in PRESENT is simply dropped
      r_out_valid <= 1'b0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_checksum <= '0;
            if (i_len != '0) begin
              r_remaining <= i_len;
            end
          end
        end
        S_FETCH: begin
          if (w_read) begin
            r_out_data  <= i_fifo_data;
            r_out_valid <= 1'b1;
            r_checksum  <= r_checksum + i_fifo_data;
            r_remaining <= r_remaining - CNT_W'(1);
          end
        end
        S_PRESENT: begin
          if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_read      = w_read;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_checksum  = r_checksum;
  assign o_remaining = r_remaining;

endmodule

// File: tb/tb_fifo_batch_reader.sv
// tb/tb_fifo_batch_reader.sv - directed self-checking bench for fifo_batch_reader
module tb_fifo_batch_reader;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [4:0] len;
  logic       abort;
  logic       f_empty_n;
  logic [7:0] fifo_data;
  logic       rd;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [7:0] checksum;
  logic [4:0] remaining;

  // FIFO model: show-ahead head word, popped on an edge with READ=1
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  logic       stall;

  int cyc_cnt;
  int read_cnt;
  int done_cnt;
  int valid_cnt;
  int acc_n;
  logic [7:0] acc [0:255];
  int e0_mark;

  int checks;
  int failures;

  fifo_batch_reader #(.DATA_W(8), .CNT_W(5)) dut (
    .i_clock     (clk),
    .i_reset_n   (resetn),
    .i_start     (start),
    .i_len       (len),
    .i_abort     (abort),
    .i_f_empty_n (f_empty_n),
    .i_fifo_data (fifo_data),
    .o_read      (rd),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_checksum  (checksum),
    .o_remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_data = mem[rd_ptr];
  assign f_empty_n = (wr_ptr != rd_ptr) && !stall;

  // Edge monitor: FIFO pops, accepted words, pulses and a free-running cycle count
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rd) begin
      rd_ptr   <= rd_ptr + 8'd1;
      read_cnt <= read_cnt + 1;
    end
    if (out_valid && out_ready) begin
      acc[acc_n[7:0]] <= out_data;
      acc_n           <= acc_n + 1;
    end
    if (done)      done_cnt  <= done_cnt + 1;
    if (out_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Presents START for one edge (E0); returns at the negedge of cycle 1 after E0
  task automatic start_batch(input logic [4:0] n);
    @(negedge clk);
    start = 1'b1;
    len   = n;
    @(negedge clk);
    start   = 1'b0;
    e0_mark = cyc_cnt;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    int k;
    k = 0;
    while (!done && k < limit) begin
      @(negedge clk);
      k = k + 1;
    end
    if (!done) check("done_timeout", 0, 1);
    cyc = cyc_cnt - e0_mark + 1;
  endtask

  initial begin
    int c;
    int r0;
    int a0;
    int d0;
    int v0;
    int bad;

    checks = 0; failures = 0;
    cyc_cnt = 0; read_cnt = 0; done_cnt = 0; valid_cnt = 0; acc_n = 0;
    wr_ptr = 8'd0; rd_ptr = 8'd0; stall = 1'b0;
    resetn = 1'b0; start = 1'b0; len = 5'd0; abort = 1'b0; out_ready = 1'b1;

    // Reset for one cycle, then release
    @(negedge clk);
    resetn = 1'b1;
    check("rst_read", rd, 0);
    check("rst_out_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum, 0);
    check("rst_remaining", remaining, 0);

    // START with an empty FIFO: no pop while waiting in FETCH
    start_batch(5'd1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (rd !== 1'b0 || busy !== 1'b1) bad = bad + 1;
      @(negedge clk);
    end
    check("empty_start_no_read", bad, 0);
    check("empty_start_reads", read_cnt, 0);
    abort = 1'b1;
    check("abort_forces_read_low", rd, 0);
    @(negedge clk);
    abort = 1'b0;
    check("empty_abort_idle", busy, 0);

    // Basic batch 11, 22, 33
    push(8'd11); push(8'd22); push(8'd33);
    r0 = read_cnt; a0 = acc_n;
    start_batch(5'd3);
    wait_done(40, c);
    check("basic_done_cycle", c, 7);
    @(negedge clk);
    check("basic_reads", read_cnt - r0, 3);
    check("basic_word0", acc[a0[7:0]], 11);
    check("basic_word1", acc[8'(a0 + 1)], 22);
    check("basic_word2", acc[8'(a0 + 2)], 33);
    check("basic_checksum", checksum, 66);
    check("basic_busy_after", busy, 0);
    check("basic_done_after", done, 0);

    // Downstream backpressure for 5 cycles on the first word
    push(8'd11); push(8'd22);
    r0 = read_cnt;
    out_ready = 1'b0;
    start_batch(5'd2);
    @(negedge clk);
    check("bp_first_valid", out_valid, 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'd11 || rd !== 1'b0) bad = bad + 1;
      @(negedge clk);
    end
    check("bp_hold", bad, 0);
    out_ready = 1'b1;
    wait_done(40, c);
    check("bp_done_cycle", c, 10);
    check("bp_reads", read_cnt - r0, 2);
    check("bp_checksum", checksum, 33);

    // FIFO empty for 3 cycles in FETCH
    stall = 1'b1;
    push(8'd5); push(8'd6);
    start_batch(5'd2);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (rd !== 1'b0 || remaining !== 5'd2) bad = bad + 1;
      @(negedge clk);
    end
    check("stall_hold", bad, 0);
    stall = 1'b0;
    wait_done(40, c);
    check("stall_done_cycle", c, 8);
    check("stall_checksum", checksum, 11);

    // Checksum wrap; a second START during BUSY is ignored
    push(8'd200); push(8'd100);
    r0 = read_cnt;
    start_batch(5'd2);
    @(negedge clk);
    start = 1'b1;
    len   = 5'd31;
    @(negedge clk);
    check("busy_start_remaining_c3", remaining, 1);
    @(negedge clk);
    start = 1'b0;
    check("busy_start_remaining_c4", remaining, 0);
    wait_done(40, c);
    check("wrap_done_cycle", c, 5);
    @(negedge clk);
    check("wrap_reads", read_cnt - r0, 2);
    check("wrap_checksum", checksum, 44);
    check("wrap_idle_after", busy, 0);

    // LEN=0
    r0 = read_cnt; v0 = valid_cnt;
    start_batch(5'd0);
    wait_done(10, c);
    check("len0_done_cycle", c, 1);
    check("len0_read", rd, 0);
    @(negedge clk);
    check("len0_reads", read_cnt - r0, 0);
    check("len0_valids", valid_cnt - v0, 0);
    check("len0_checksum", checksum, 0);

    // Abort during the 3rd PRESENT of a 5-word batch
    push(8'd1); push(8'd2); push(8'd3); push(8'd4); push(8'd5);
    r0 = read_cnt; d0 = done_cnt;
    start_batch(5'd5);
    repeat (5) @(negedge clk);
    check("abort_in_present", out_valid, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_remaining", remaining, 0);
    check("abort_checksum", checksum, 6);
    check("abort_reads", read_cnt - r0, 3);
    @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    // Reset during the 3rd PRESENT (FIFO head now 4, 5, 7)
    push(8'd7); push(8'd8); push(8'd9);
    start_batch(5'd5);
    repeat (5) @(negedge clk);
    check("rstmid_in_present", out_valid, 1);
    check("rstmid_checksum_before", checksum, 16);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("rstmid_read", rd, 0);
    check("rstmid_out_data", out_data, 0);
    check("rstmid_valid", out_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_checksum", checksum, 0);
    check("rstmid_remaining", remaining, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
